mouse_delta_counter: RTL

- Upstream neighbour of the CPU-bus responder that serves JOY0DAT reads.
- Takes signed X/Y mouse delta packets delivered by the SPI user-IO block and accumulates them into Amiga-style 8-bit quadrature counters.
- Drains each axis at a bounded rate so the host never sees a jump larger than it can decode between reads.
- Output MOUSE_DATA is the 16-bit {Y,X} counter word consumed directly as JOY0DAT.

---
 rtl/mouse_delta_counter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mouse_delta_counter.sv
// rtl/mouse_delta_counter.sv - SPI mouse deltas into rate-limited Amiga-style {Y,X} quadrature counters
// Optional macro MOUSE_ACCEL_EN: doubles deltas whose magnitude exceeds ACCEL_THRESH.
`timescale 1ns/1ps
module mouse_delta_counter #(
  parameter int MAX_STEP     = 8,
  parameter int TICK_DIV     = 256,
  parameter int RES_W        = 12,
  parameter int ACCEL_THRESH = 16
) (
  input  logic        CLKCPU_A,
  input  logic        RESET,
  input  logic        DELTA_TOGGLE,
  input  logic [7:0]  DELTA_X,
  input  logic [7:0]  DELTA_Y,
  input  logic        CLEAR,
  output logic [15:0] MOUSE_DATA,
  output logic        PENDING,
  output logic        OVERFLOW
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = RES_W + 2;
  localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic signed [AW-1:0] STEP_MAX  = AW'(MAX_STEP);
  localparam logic signed [AW-1:0] RES_MAX   = AW'((1 << (RES_W - 1)) - 1);
  localparam logic signed [AW-1:0] RES_MIN   = -RES_MAX;
`ifdef MOUSE_ACCEL_EN
  localparam logic signed [8:0]    ACCEL_LIM = 9'(ACCEL_THRESH);
`endif

  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic                    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic                    boot_q, boot_d, arm_q, arm_d;
  logic signed [RES_W-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
  logic [7:0]              cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic                    overflow_q, overflow_d;

  logic                    tick, accept, ovf_x, ovf_y;
  logic signed [8:0]       dx, dy;
  logic signed [AW-1:0]    step_x, step_y;

  function automatic logic signed [8:0] shape_delta(input logic [7:0] d);
    logic signed [8:0] dv;
    dv = {d[7], d};
`ifdef MOUSE_ACCEL_EN
    if ((dv > ACCEL_LIM) || (dv < -ACCEL_LIM)) dv = dv <<< 1;
`endif
    return dv;
  endfunction

  function automatic logic signed [AW-1:0] clamp_step(input logic signed [RES_W-1:0] r);
    logic signed [AW-1:0] rr;
    rr = {{(AW-RES_W){r[RES_W-1]}}, r};
    if (rr > STEP_MAX)  return STEP_MAX;
    if (rr < -STEP_MAX) return -STEP_MAX;
    return rr;
  endfunction

  // Returns {clipped, new residue}; anything beyond the symmetric limit is discarded.
  function automatic logic [RES_W:0] accumulate(input logic signed [RES_W-1:0] r,
                                                input logic signed [8:0]       d,
                                                input logic signed [AW-1:0]    step);
    logic signed [AW-1:0] sum;
    sum = {{(AW-RES_W){r[RES_W-1]}}, r} + {{(AW-9){d[8]}}, d} - step;
    if (sum > RES_MAX) return {1'b1, RES_MAX[RES_W-1:0]};
    if (sum < RES_MIN) return {1'b1, RES_MIN[RES_W-1:0]};
    return {1'b0, sum[RES_W-1:0]};
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Until armed the edge flop shadows s2's next value, so a level already high at release is not an edge.
    boot_d = 1'b1;
    arm_d  = boot_q;
    s1_d   = DELTA_TOGGLE;
    s2_d   = s1_q;
    s3_d   = arm_q ? s2_q : s1_q;
    accept = arm_q & (s2_q ^ s3_q);

    dx     = accept ? shape_delta(DELTA_X) : '0;
    dy     = accept ? shape_delta(DELTA_Y) : '0;
    step_x = tick ? clamp_step(res_x_q) : '0;
    step_y = tick ? clamp_step(res_y_q) : '0;

    {ovf_x, res_x_d} = accumulate(res_x_q, dx, step_x);
    {ovf_y, res_y_d} = accumulate(res_y_q, dy, step_y);
    cnt_x_d          = cnt_x_q + step_x[7:0];
    cnt_y_d          = cnt_y_q + step_y[7:0];
    overflow_d       = overflow_q | ovf_x | ovf_y;

    if (CLEAR) begin
      res_x_d    = '0;
      res_y_d    = '0;
      cnt_x_d    = '0;
      cnt_y_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLKCPU_A) begin
    if (RESET) begin
      tick_cnt_q <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      boot_q     <= 1'b0;
      arm_q      <= 1'b0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      boot_q     <= boot_d;
      arm_q      <= arm_d;
      res_x_q    <= res_x_d;
      res_y_q    <= res_y_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      overflow_q <= overflow_d;
    end
  end

  assign MOUSE_DATA = {cnt_y_q, cnt_x_q};
  assign PENDING    = (res_x_q != '0) | (res_y_q != '0);
  assign OVERFLOW   = overflow_q;

endmodule
